fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the single-cycle datapath. Owns the fetch PC and issues word reads to a synchronous instruction memory with a fixed 1-cycle latency. Buffers returned words in a small prefetch queue and presents them, with their PC, over a valid/ready handshake. Accepts branch/jump redirects from the datapath and flushes wrong-path work.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_queue.sv | 97 +++++++++
 rtl/fetch_queue_chk.sv | 28 ++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   INSTR_W / PC_W : instruction word and program-counter widths
//   PC_INC         : byte increment between sequential fetches
//   fetch_entry_t  : one prefetch-queue entry {instr, pc}
//   align_pc()     : forces a byte address onto a word boundary
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   localparam logic [PC_W-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

   localparam int ENTRY_W = INSTR_W + PC_W;

   // Redirect targets may carry byte-offset bits; fetch only whole words.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry FIFO of {instr, pc} entries with a registered head.
// Entry 0 is always the head; a pop shifts the remaining entries down.
// When the queue drains, the head register keeps its last contents so the
// outputs downstream hold their value while invalid.
//   clock, Reset   : clock and asynchronous active-high reset
//   push_i         : write push_entry_i behind the current tail
//   push_entry_i   : entry to write
//   pop_i          : consume the head (ignored when empty)
//   flush_i        : empty the queue; wins over a simultaneous push
//   count_o        : occupancy
//   head_o         : head entry (registered)
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic             push_i,
   input  fetch_entry_t     push_entry_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [CNT_W-1:0] count_o,
   output fetch_entry_t     head_o
);

   fetch_entry_t     ent_q [DEPTH];
   fetch_entry_t     ent_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             do_pop_s;
   logic [CNT_W-1:0] base_s;

   // Next-state for entries and occupancy.
   always_comb begin
      do_pop_s = pop_i && (count_q != '0);
      // Slot the pushed entry lands in, after any pop has shifted the queue.
      base_s   = count_q - CNT_W'(do_pop_s);
      count_d  = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
      end
      if (flush_i) begin
         // A same-cycle pop has already been honoured by the consumer; no
         // shift so the head keeps showing the consumed entry.
         count_d = '0;
      end else begin
         // A pop of the last entry leaves the head register untouched.
         if (do_pop_s && (count_q > CNT_W'(1))) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               ent_d[i] = ent_q[i + 1];
            end
         end else begin
            count_d = count_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (push_i && (base_s == CNT_W'(i))) ? push_entry_i : ent_d[i];
         end
         count_d = count_q - CNT_W'(do_pop_s) + CNT_W'(push_i);
      end
   end

   // Entry and occupancy registers.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = ent_q[0];

   fetch_queue_chk #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_chk (
      .clock   (clock),
      .Reset   (Reset),
      .push_i  (push_i),
      .pop_i   (do_pop_s),
      .flush_i (flush_i),
      .count_i (count_q)
   );

endmodule

// File: rtl/fetch_queue_chk.sv
// -----------------------------------------------------------------------------
// fetch_queue_chk
// Property checker bound into fetch_queue. Flags a push into a full queue
// that is not accompanied by a pop (or cancelled by a flush).
//   clock, Reset      : clock and asynchronous active-high reset
//   push_i/pop_i      : queue push / pop strobes
//   flush_i           : queue flush (overrides push)
//   count_i           : current occupancy
// -----------------------------------------------------------------------------
module fetch_queue_chk #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input logic             clock,
   input logic             Reset,
   input logic             push_i,
   input logic             pop_i,
   input logic             flush_i,
   input logic [CNT_W-1:0] count_i
);

   // Overflow would silently drop an instruction.
   a_no_overflow : assert property (
      @(posedge clock) disable iff (Reset)
      !(push_i && !pop_i && !flush_i && (count_i == CNT_W'(DEPTH)))
   );

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the fetch PC, issues word reads to a
// synchronous 1-cycle-latency instruction memory, buffers returned words in
// a prefetch queue and presents them over a valid/ready handshake. Redirects
// flush the queue and kill the outstanding response.
//   clock          : rising-edge clock
//   Reset          : asynchronous active-high reset
//   imem_req       : read request this cycle
//   imem_addr      : word address (fetch_pc[ADDR_W+1:2])
//   imem_rdata     : read data, valid the cycle after imem_req
//   redirect_valid : taken branch/jump; flush and refetch
//   redirect_pc    : new PC (bits [1:0] ignored)
//   out_valid      : out_instr/out_pc hold a valid instruction
//   out_ready      : consumer accepts the head entry
//   out_instr      : instruction word
//   out_pc         : byte address of out_instr
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              ADDR_W   = 8,
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clock,
   input  logic               Reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  fetch_pc_q;
   logic [PC_W-1:0]  fetch_pc_d;
   logic             inflight_q;
   logic             inflight_d;
   logic [PC_W-1:0]  req_pc_q;
   logic [PC_W-1:0]  req_pc_d;

   logic [CNT_W-1:0] count_s;
   logic [CNT_W:0]   credit_s;
   logic             pop_s;
   logic             push_s;
   logic [PC_W+1:0]  pc_ext_s;
   fetch_entry_t     push_entry_s;
   fetch_entry_t     head_s;
   logic             unused_ok_s;

   // Widened PC so ADDR_W up to 32 can be sliced out of bits [ADDR_W+1:2].
   assign pc_ext_s  = {2'b00, fetch_pc_q};
   assign imem_addr = pc_ext_s[ADDR_W+1:2];

   assign out_valid = (count_s != '0);
   assign out_instr = head_s.instr;
   assign out_pc    = head_s.pc;

   // Handshake, credit and request logic.
   always_comb begin
      pop_s    = out_valid && out_ready;
      // Slots already claimed after this cycle: stored + outstanding - leaving.
      credit_s = {1'b0, count_s} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop_s);
      if (Reset || redirect_valid) begin
         imem_req = 1'b0;
      end else begin
         imem_req = (credit_s < (CNT_W + 1)'(DEPTH));
      end
      // A redirect kills the response arriving this cycle.
      push_s             = inflight_q && !redirect_valid;
      push_entry_s.instr = imem_rdata;
      push_entry_s.pc    = req_pc_q;
   end

   // Next fetch PC and in-flight tracking.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = imem_req;
      if (redirect_valid) begin
         fetch_pc_d = align_pc(redirect_pc);
      end else if (imem_req) begin
         fetch_pc_d = fetch_pc_q + PC_INC;
         req_pc_d   = fetch_pc_q;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
   end

   // PC and in-flight registers.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         req_pc_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         req_pc_q   <= req_pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clock        (clock),
      .Reset        (Reset),
      .push_i       (push_s),
      .push_entry_i (push_entry_s),
      .pop_i        (pop_s),
      .flush_i      (redirect_valid),
      .count_o      (count_s),
      .head_o       (head_s)
   );

   assign unused_ok_s = ^{redirect_pc[1:0], pc_ext_s};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_valid;
      logic        e_req;
      logic [31:0] e_pc;
   } vec_t;

   logic        clock;
   logic        Reset;
   logic        imem_req,  imem_req2;
   logic [7:0]  imem_addr;
   logic [31:0] imem_addr2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic        rv, rv2;
   logic [31:0] rpc, rpc2;
   logic        out_valid, out_valid2;
   logic        rdy, rdy2;
   logic [31:0] out_instr, out_instr2;
   logic [31:0] out_pc, out_pc2;

   int   n_vec;
   int   n_mis;
   vec_t tbl[$];

   fetch_unit #(.ADDR_W(8), .DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .Reset(Reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(rv), .redirect_pc(rpc),
      .out_valid(out_valid), .out_ready(rdy),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   fetch_unit #(.ADDR_W(32), .DEPTH(2), .RESET_PC(32'h0000_0000)) dut32 (
      .clock(clock), .Reset(Reset),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .redirect_valid(rv2), .redirect_pc(rpc2),
      .out_valid(out_valid2), .out_ready(rdy2),
      .out_instr(out_instr2), .out_pc(out_pc2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory contents: word k holds 0x1000_0000 + k.
   function automatic logic [31:0] memfn(input logic [31:0] pc);
      return 32'h1000_0000 + ((pc >> 2) & 32'h0000_00FF);
   endfunction

   function automatic logic [31:0] memfn32(input logic [31:0] pc);
      return 32'h1000_0000 + (pc >> 2);
   endfunction

   // Synchronous 1-cycle instruction memories.
   always @(posedge clock) begin
      if (imem_req)  imem_rdata  <= 32'h1000_0000 + {24'h0, imem_addr};
      if (imem_req2) imem_rdata2 <= 32'h1000_0000 + imem_addr2;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [31:0] p, input logic rd,
                               input logic ev, input logic er, input logic [31:0] ep);
      vec_t v;
      v.rv = r; v.rpc = p; v.rdy = rd; v.e_valid = ev; v.e_req = er; v.e_pc = ep;
      return v;
   endfunction

   initial begin
      logic [31:0] exp_pc;
      int          since;

      n_vec = 0; n_mis = 0;
      Reset = 1'b1; rv = 1'b0; rpc = '0; rdy = 1'b0;
      rv2 = 1'b0; rpc2 = '0; rdy2 = 1'b1;

      // Start-up stream, 6-cycle stall, redirect with full queue,
      // redirect+pop, back-to-back redirects, unaligned target.
      tbl.push_back(mk(0, 0, 1, 0, 1, 0));                         // v0
      tbl.push_back(mk(0, 0, 1, 0, 1, 0));                         // v1
      for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 1, 1, 1, 32'(4 * k)));   // v2-v5
      for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 0, 0, 1, 0, 32'h10));      // v6-v11
      for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 1, 1, 1, 32'(16 + 4 * k))); // v12-v15
      tbl.push_back(mk(0, 0, 0, 1, 0, 32'h20));                    // v16
      tbl.push_back(mk(1, 32'h40, 0, 1, 0, 32'h20));               // v17 redirect, queue full
      tbl.push_back(mk(0, 0, 1, 0, 1, 0));                         // v18
      tbl.push_back(mk(0, 0, 1, 0, 1, 0));                         // v19
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h40));                    // v20
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h44));                    // v21
      tbl.push_back(mk(1, 32'h43, 1, 1, 0, 32'h48));               // v22 redirect + pop
      tbl.push_back(mk(1, 32'h80, 1, 0, 0, 0));                    // v23 back-to-back
      tbl.push_back(mk(0, 0, 1, 0, 1, 0));                         // v24
      tbl.push_back(mk(0, 0, 1, 0, 1, 0));                         // v25
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h80));                    // v26
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h84));                    // v27
      tbl.push_back(mk(1, 32'h43, 1, 1, 0, 32'h88));               // v28 unaligned target
      tbl.push_back(mk(0, 0, 1, 0, 1, 0));                         // v29
      tbl.push_back(mk(0, 0, 1, 0, 1, 0));                         // v30
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h40));                    // v31
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h44));                    // v32

      repeat (3) @(posedge clock);
      @(negedge clock); #1;
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_pc",    out_pc, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_req",   {31'b0, imem_req}, 32'd0);

      @(negedge clock);
      Reset = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         if (i != 0) @(negedge clock);
         rv = tbl[i].rv; rpc = tbl[i].rpc; rdy = tbl[i].rdy;
         #1;
         chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
         chk($sformatf("v%0d_req", i),   {31'b0, imem_req},  {31'b0, tbl[i].e_req});
         if (tbl[i].e_valid) begin
            chk($sformatf("v%0d_pc", i),    out_pc,    tbl[i].e_pc);
            chk($sformatf("v%0d_instr", i), out_instr, memfn(tbl[i].e_pc));
         end
      end

      // Randomised run against an in-order stream model.
      exp_pc = 32'h48;
      since  = 5;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 9) == 0);
         rpc = $urandom_range(0, 1023);
         #1;
         chk($sformatf("r%0d_valid", c), {31'b0, out_valid}, (since >= 3) ? 32'd1 : 32'd0);
         if (rv) chk($sformatf("r%0d_req", c), {31'b0, imem_req}, 32'd0);
         if (out_valid && rdy) begin
            chk($sformatf("r%0d_pc", c),    out_pc,    exp_pc);
            chk($sformatf("r%0d_instr", c), out_instr, memfn(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
         if (rv) begin
            exp_pc = rpc & 32'hFFFF_FFFC;
            since  = 1;
         end else if (since < 100) begin
            since = since + 1;
         end
      end

      // Asynchronous reset between edges while a response is in flight.
      @(negedge clock);
      rv = 1'b0; rdy = 1'b1;
      repeat (6) @(negedge clock);
      @(posedge clock); #3;
      Reset = 1'b1;
      #1;
      chk("areset_valid", {31'b0, out_valid}, 32'd0);
      chk("areset_pc",    out_pc, 32'd0);
      chk("areset_instr", out_instr, 32'd0);
      chk("areset_req",   {31'b0, imem_req}, 32'd0);
      @(negedge clock);
      Reset = 1'b0;
      #1;
      chk("arel1_valid", {31'b0, out_valid}, 32'd0);
      chk("arel1_req",   {31'b0, imem_req}, 32'd1);
      @(negedge clock); #1;
      chk("arel2_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clock); #1;
      chk("arel3_valid", {31'b0, out_valid}, 32'd1);
      chk("arel3_pc",    out_pc, 32'd0);
      chk("arel3_instr", out_instr, memfn(32'd0));
      @(negedge clock); #1;
      chk("arel4_pc",    out_pc, 32'd4);
      chk("arel4_instr", out_instr, memfn(32'd4));

      // 32-bit PC wrap on the ADDR_W=32 instance.
      @(negedge clock);
      rv2 = 1'b1; rpc2 = 32'hFFFF_FFF8; rdy2 = 1'b1;
      #1;
      chk("wrap_req_t", {31'b0, imem_req2}, 32'd0);
      @(negedge clock);
      rv2 = 1'b0;
      #1;
      chk("wrap_t1_valid", {31'b0, out_valid2}, 32'd0);
      @(negedge clock); #1;
      chk("wrap_t2_valid", {31'b0, out_valid2}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         logic [31:0] wpc;
         wpc = 32'hFFFF_FFF8 + 32'(4 * k);
         @(negedge clock); #1;
         chk($sformatf("wrap%0d_valid", k), {31'b0, out_valid2}, 32'd1);
         chk($sformatf("wrap%0d_pc", k),    out_pc2, wpc);
         chk($sformatf("wrap%0d_instr", k), out_instr2, memfn32(wpc));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
